// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Two requester ports plus the shared memory port of dmem_arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [31:0]           m0_wdata;
    logic [2:0]            m0_mode;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [31:0]           m0_rdata;
    logic                  m0_err;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [31:0]           m1_wdata;
    logic [2:0]            m1_mode;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [31:0]           m1_rdata;
    logic                  m1_err;

    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data_in;
    logic [2:0]            mem_mode;
    logic [31:0]           mem_data_out;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output mem_write, mem_addr, mem_data_in, mem_mode,
        input  mem_data_out
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_mode,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_mode,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  mem_write, mem_addr, mem_data_in, mem_mode,
        output mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin two-port arbiter in front of a single data memory.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [2:0] c_MODE_B  = 3'b000;
    localparam logic [2:0] c_MODE_H  = 3'b001;
    localparam logic [2:0] c_MODE_W  = 3'b010;
    localparam logic [2:0] c_MODE_BU = 3'b100;
    localparam logic [2:0] c_MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_last;     // 1 = requester 1 was granted last
    logic                  r_id;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_mode;
    logic [31:0]           r_rdata;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_err;
    logic                  w_mem_write;
    logic                  w_rvalid0;
    logic                  w_rvalid1;

    function automatic logic f_access_err(input logic [2:0] mode, input logic [1:0] lsb);
        logic err;
        case (mode)
            c_MODE_B, c_MODE_BU: err = 1'b0;
            c_MODE_H, c_MODE_HU: err = lsb[0];
            c_MODE_W:            err = (lsb != 2'b00);
            default:             err = 1'b1;
        endcase
        return err;
    endfunction

    // Error is derived from the latched fields so it stays stable through RESP.
    assign w_err     = f_access_err(r_mode, r_addr[1:0]);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_mem_write  = 1'b0;
        w_rvalid0    = 1'b0;
        w_rvalid1    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    if (bus.m0_req && bus.m1_req) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = bus.m0_req;
                        w_gnt1 = bus.m1_req;
                    end
                end
                if (w_gnt0 || w_gnt1) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_mem_write  = r_we & ~w_err;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                w_rvalid0    = ~r_id;
                w_rvalid1    = r_id;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mode  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_any_gnt) begin
                r_last  <= w_gnt1;
                r_id    <= w_gnt1;
                r_we    <= w_gnt1 ? bus.m1_we    : bus.m0_we;
                r_addr  <= w_gnt1 ? bus.m1_addr  : bus.m0_addr;
                r_wdata <= w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
                r_mode  <= w_gnt1 ? bus.m1_mode  : bus.m0_mode;
            end
            if (r_state == S_ACCESS) begin
                r_rdata <= (!r_we && !w_err) ? bus.mem_data_out : 32'h0;
            end
        end
    end

    assign bus.m0_gnt      = w_gnt0;
    assign bus.m1_gnt      = w_gnt1;
    assign bus.m0_rvalid   = w_rvalid0;
    assign bus.m1_rvalid   = w_rvalid1;
    assign bus.m0_rdata    = w_rvalid0 ? r_rdata : 32'h0;
    assign bus.m1_rdata    = w_rvalid1 ? r_rdata : 32'h0;
    assign bus.m0_err      = w_rvalid0 & w_err;
    assign bus.m1_err      = w_rvalid1 & w_err;

    assign bus.mem_write   = w_mem_write;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_data_in = r_wdata;
    assign bus.mem_mode    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Randomised bench for dmem_arbiter with a byte-level memory model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam int HALF  = 5;
    localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010, M_BU = 3'b100, M_HU = 3'b101;

    logic clk = 1'b0;
    logic rst;
    always #HALF clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
    dmem_arbiter #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    bit mdl_last;

    // Memory contents are a fixed per-address pattern XOR an overlay of writes.
    bit [7:0] mem_x [DEPTH];
    bit [7:0] exp_x [DEPTH];

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 73) ^ (i >>> 3) ^ 90);
    endfunction

    always_comb begin
        int a;
        logic [7:0] b0, b1, b2, b3;
        a  = int'(bus.mem_addr);
        b0 = mem_x[a] ^ pat(a);
        b1 = mem_x[(a + 1) % DEPTH] ^ pat((a + 1) % DEPTH);
        b2 = mem_x[(a + 2) % DEPTH] ^ pat((a + 2) % DEPTH);
        b3 = mem_x[(a + 3) % DEPTH] ^ pat((a + 3) % DEPTH);
        case (bus.mem_mode)
            M_B:     bus.mem_data_out = {{24{b0[7]}}, b0};
            M_BU:    bus.mem_data_out = {24'h0, b0};
            M_H:     bus.mem_data_out = {{16{b1[7]}}, b1, b0};
            M_HU:    bus.mem_data_out = {16'h0, b1, b0};
            M_W:     bus.mem_data_out = {b3, b2, b1, b0};
            default: bus.mem_data_out = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) begin
            int a, n;
            a = int'(bus.mem_addr);
            n = (bus.mem_mode[1:0] == 2'b00) ? 1 : (bus.mem_mode[1:0] == 2'b01) ? 2 : 4;
            for (int k = 0; k < 4; k++)
                if (k < n) mem_x[(a + k) % DEPTH] <= bus.mem_data_in[8*k +: 8] ^ pat((a + k) % DEPTH);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic mdl_err(input logic [2:0] mode, input logic [AW-1:0] addr);
        if (mode == 3'b011 || mode == 3'b110 || mode == 3'b111) return 1'b1;
        if ((mode == M_H || mode == M_HU) && (addr % 2 != 0)) return 1'b1;
        if (mode == M_W && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] mdl_byte(input int a);
        return exp_x[a % DEPTH] ^ pat(a % DEPTH);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] mode, input logic [AW-1:0] addr);
        int a;
        int v;
        a = int'(addr);
        case (mode)
            M_B:  begin v = int'(mdl_byte(a)); if (v >= 128) v = v - 256; end
            M_BU: v = int'(mdl_byte(a));
            M_H:  begin v = int'(mdl_byte(a)) + 256 * int'(mdl_byte(a + 1)); if (v >= 32768) v = v - 65536; end
            M_HU: v = int'(mdl_byte(a)) + 256 * int'(mdl_byte(a + 1));
            default: v = int'({mdl_byte(a + 3), mdl_byte(a + 2), mdl_byte(a + 1), mdl_byte(a)});
        endcase
        return 32'(v);
    endfunction

    task automatic mdl_store(input logic [2:0] mode, input logic [AW-1:0] addr, input logic [31:0] data);
        int a, n;
        a = int'(addr);
        n = (mode == M_W) ? 4 : (mode == M_H || mode == M_HU) ? 2 : 1;
        for (int k = 0; k < n; k++) exp_x[(a + k) % DEPTH] = data[8*k +: 8] ^ pat((a + k) % DEPTH);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input bit id, input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [2:0] mode);
        if (id == 1'b0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_mode = mode;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_mode = mode;
        end
    endtask

    task automatic drop_req(input bit id);
        set_req(id, 1'b0, 1'($urandom), AW'($urandom), $urandom, 3'($urandom));
    endtask

    task automatic peek(input bit id, output logic g_me, output logic g_ot, output logic v_me,
                        output logic v_ot, output logic e_me, output logic e_ot,
                        output logic [31:0] d_me, output logic [31:0] d_ot);
        g_me = id ? bus.m1_gnt    : bus.m0_gnt;    g_ot = id ? bus.m0_gnt    : bus.m1_gnt;
        v_me = id ? bus.m1_rvalid : bus.m0_rvalid; v_ot = id ? bus.m0_rvalid : bus.m1_rvalid;
        e_me = id ? bus.m1_err    : bus.m0_err;    e_ot = id ? bus.m0_err    : bus.m1_err;
        d_me = id ? bus.m1_rdata  : bus.m0_rdata;  d_ot = id ? bus.m0_rdata  : bus.m1_rdata;
    endtask

    // Full transaction starting just after a rising edge with the arbiter idle.
    task automatic run_txn(input bit id, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [2:0] mode, input string tag);
        logic g_me, g_ot, v_me, v_ot, e_me, e_ot, exp_err, exp_wr;
        logic [31:0] d_me, d_ot, exp_rd;
        int waited;
        bit got;
        set_req(id, 1'b1, we, addr, wdata, mode);
        got = 1'b0;
        waited = 0;
        while (!got && waited < 6) begin
            @(negedge clk);
            peek(id, g_me, g_ot, v_me, v_ot, e_me, e_ot, d_me, d_ot);
            if (g_me === 1'b1) got = 1'b1;
            else begin waited++; @(posedge clk); #1; end
        end
        n_cmp++;
        if (!got || waited != 0) begin
            n_bad++;
            $display("FAIL %s grant: got granted=%0b after %0d cycles, expected granted=1 after 0", tag, got, waited);
        end
        if (!got) begin drop_req(id); return; end
        n_cmp++;
        if (g_ot !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_bad++;
            $display("FAIL %s grant-cycle: got other_gnt=%b mem_write=%b, expected 0 0", tag, g_ot, bus.mem_write);
        end
        exp_err = mdl_err(mode, addr);
        exp_wr  = we & ~exp_err;
        exp_rd  = (!we && !exp_err) ? mdl_load(mode, addr) : 32'h0;
        mdl_last = id;
        @(posedge clk); #1;
        drop_req(id);
        @(negedge clk);
        n_cmp++;
        if (bus.mem_write !== exp_wr) begin
            n_bad++;
            $display("FAIL %s mem_write: got %b expected %b", tag, bus.mem_write, exp_wr);
        end
        n_cmp++;
        if (bus.mem_addr !== addr || bus.mem_data_in !== wdata || bus.mem_mode !== mode) begin
            n_bad++;
            $display("FAIL %s mem-port: got %h/%h/%b expected %h/%h/%b", tag,
                     bus.mem_addr, bus.mem_data_in, bus.mem_mode, addr, wdata, mode);
        end
        @(posedge clk); #1;
        @(negedge clk);
        peek(id, g_me, g_ot, v_me, v_ot, e_me, e_ot, d_me, d_ot);
        n_cmp++;
        if (v_me !== 1'b1 || d_me !== exp_rd || e_me !== exp_err) begin
            n_bad++;
            $display("FAIL %s response: got rvalid=%b rdata=%h err=%b expected 1 %h %b", tag, v_me, d_me, e_me, exp_rd, exp_err);
        end
        n_cmp++;
        if (v_ot !== 1'b0 || d_ot !== 32'h0 || e_ot !== 1'b0 || bus.mem_write !== 1'b0 || g_me !== 1'b0) begin
            n_bad++;
            $display("FAIL %s resp-other: got rvalid=%b rdata=%h err=%b wr=%b gnt=%b expected all 0", tag, v_ot, d_ot, e_ot, bus.mem_write, g_me);
        end
        if (exp_wr) mdl_store(mode, addr, wdata);
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 12'h010, 32'h1234_5678, M_W);
        set_req(1'b1, 1'b1, 1'b0, 12'h020, 32'h8765_4321, M_W);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err, bus.mem_write} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset-ctrl: got gnt=%b%b rv=%b%b err=%b%b wr=%b expected all 0", bus.m0_gnt, bus.m1_gnt,
                     bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err, bus.mem_write);
        end
        n_cmp++;
        if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset-rdata: got %h %h expected 0 0", bus.m0_rdata, bus.m1_rdata);
        end
        n_cmp++;
        if (bus.mem_addr !== '0 || bus.mem_data_in !== 32'h0 || bus.mem_mode !== 3'b0) begin
            n_bad++;
            $display("FAIL reset-memport: got %h/%h/%b expected 0", bus.mem_addr, bus.mem_data_in, bus.mem_mode);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        logic [31:0] rd0, rd1;
        set_req(1'b0, 1'b1, 1'b0, 12'h100, 32'hAAAA_0000, M_W);
        set_req(1'b1, 1'b1, 1'b0, 12'h104, 32'hBBBB_0000, M_W);
        rd0 = mdl_load(M_W, 12'h100);
        rd1 = mdl_load(M_W, 12'h104);
        rst = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.m0_gnt !== (cyc == 0 || cyc == 6) || bus.m1_gnt !== (cyc == 3 || cyc == 9)) begin
                n_bad++;
                $display("FAIL arb-gnt cyc%0d: got %b%b", cyc, bus.m0_gnt, bus.m1_gnt);
            end
            n_cmp++;
            if (bus.m0_rvalid !== (cyc == 2 || cyc == 8) || bus.m1_rvalid !== (cyc == 5 || cyc == 11)) begin
                n_bad++;
                $display("FAIL arb-rvalid cyc%0d: got %b%b", cyc, bus.m0_rvalid, bus.m1_rvalid);
            end
            n_cmp++;
            if (bus.m0_rdata !== ((cyc == 2 || cyc == 8) ? rd0 : 32'h0) ||
                bus.m1_rdata !== ((cyc == 5 || cyc == 11) ? rd1 : 32'h0)) begin
                n_bad++;
                $display("FAIL arb-rdata cyc%0d: got %h %h expected %h %h", cyc, bus.m0_rdata, bus.m1_rdata, rd0, rd1);
            end
            @(posedge clk); #1;
        end
        drop_req(1'b0);
        drop_req(1'b1);
        mdl_last = 1'b1;
    endtask

    task automatic test_word();
        run_txn(1'b0, 1'b1, 12'h010, 32'hDEAD_BEEF, M_W, "word-store");
        run_txn(1'b0, 1'b0, 12'h010, 32'h0, M_W, "word-load");
    endtask

    task automatic test_sign();
        run_txn(1'b0, 1'b1, 12'h021, 32'h0000_0080, M_B, "sign-stB");
        run_txn(1'b1, 1'b0, 12'h021, 32'h0, M_B, "sign-ldB");
        run_txn(1'b0, 1'b0, 12'h021, 32'h0, M_BU, "sign-ldBU");
        run_txn(1'b1, 1'b1, 12'h020, 32'h0000_8000, M_W, "sign-stW");
        run_txn(1'b0, 1'b0, 12'h020, 32'h0, M_H, "sign-ldH");
        run_txn(1'b1, 1'b0, 12'h020, 32'h0, M_HU, "sign-ldHU");
    endtask

    task automatic test_misalign();
        run_txn(1'b1, 1'b1, 12'h013, 32'h5555_AAAA, M_W, "mis-stW");
        run_txn(1'b1, 1'b0, 12'h010, 32'h0, M_W, "mis-ldW");
        run_txn(1'b0, 1'b1, 12'h011, 32'h0000_7777, M_H, "mis-stH");
        run_txn(1'b0, 1'b0, 12'h010, 32'h0, 3'b011, "mis-mode3");
        run_txn(1'b1, 1'b1, 12'h018, 32'h1111_2222, 3'b111, "mis-mode7");
    endtask

    task automatic test_reset_mid();
        run_txn(1'b0, 1'b1, 12'h030, 32'h1122_3344, M_W, "rstmid-pre");
        set_req(1'b0, 1'b1, 1'b1, 12'h030, 32'hCAFE_F00D, M_W);
        @(negedge clk);
        n_cmp++;
        if (bus.m0_gnt !== 1'b1) begin n_bad++; $display("FAIL rstmid-gnt: got %b expected 1", bus.m0_gnt); end
        @(posedge clk); #1;
        drop_req(1'b0);
        #2;
        n_cmp++;
        if (bus.mem_write !== 1'b1) begin n_bad++; $display("FAIL rstmid-access: got mem_write=%b expected 1", bus.mem_write); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_write !== 1'b0) begin n_bad++; $display("FAIL rstmid-drop: got mem_write=%b expected 0", bus.mem_write); end
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0 || bus.mem_write !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid-stale c%0d: got rvalid=%b%b wr=%b expected 0", c, bus.m0_rvalid, bus.m1_rvalid, bus.mem_write);
            end
            @(posedge clk); #1;
        end
        run_txn(1'b0, 1'b0, 12'h030, 32'h0, M_W, "rstmid-load");
    endtask

    task automatic test_cancel();
        set_req(1'b0, 1'b1, 1'b0, 12'h040, 32'h0, M_W);
        @(negedge clk);
        n_cmp++;
        if (bus.m0_gnt !== 1'b1) begin n_bad++; $display("FAIL cancel-gnt0: got %b expected 1", bus.m0_gnt); end
        mdl_last = 1'b0;
        @(posedge clk); #1;
        drop_req(1'b0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b1, 12'h044, 32'h0BAD_0BAD, M_W);
        @(negedge clk);
        n_cmp++;
        if (bus.m1_gnt !== 1'b0 || bus.m0_rvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL cancel-resp: got m1_gnt=%b m0_rvalid=%b expected 0 1", bus.m1_gnt, bus.m0_rvalid);
        end
        #(HALF - 1);
        drop_req(1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.m1_gnt !== 1'b0 || bus.m1_rvalid !== 1'b0 || bus.mem_write !== 1'b0) begin
                n_bad++;
                $display("FAIL cancel-idle c%0d: got gnt=%b rvalid=%b wr=%b expected 0", c, bus.m1_gnt, bus.m1_rvalid, bus.mem_write);
            end
            @(posedge clk); #1;
        end
        run_txn(1'b1, 1'b0, 12'h044, 32'h0, M_W, "cancel-load");
    endtask

    task automatic pick(output logic we, output logic [2:0] mode, output logic [AW-1:0] addr, output logic [31:0] wd);
        we = 1'($urandom);
        if ($urandom % 6 == 0) mode = 3'($urandom);
        else case ($urandom % 5)
            0: mode = M_B;  1: mode = M_H;  2: mode = M_W;  3: mode = M_BU;
            default: mode = M_HU;
        endcase
        addr = AW'(32'h200 + ($urandom % 64));
        if ($urandom % 4 != 0) begin
            if (mode == M_H || mode == M_HU) addr[0] = 1'b0;
            if (mode == M_W) addr[1:0] = 2'b00;
        end
        wd = $urandom;
    endtask

    task automatic test_random();
        logic we_a, we_b;
        logic [2:0] md_a, md_b;
        logic [AW-1:0] ad_a, ad_b;
        logic [31:0] wd_a, wd_b;
        bit id, win;
        for (int i = 0; i < 40; i++) begin
            pick(we_a, md_a, ad_a, wd_a);
            if ($urandom % 4 == 0) begin
                pick(we_b, md_b, ad_b, wd_b);
                win = ~mdl_last;
                set_req(~win, 1'b1, we_b, ad_b, wd_b, md_b);
                run_txn(win, we_a, ad_a, wd_a, md_a, "rnd-tie-win");
                run_txn(~win, we_b, ad_b, wd_b, md_b, "rnd-tie-lose");
            end else begin
                id = 1'($urandom);
                run_txn(id, we_a, ad_a, wd_a, md_a, "rnd-single");
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(1'b0, 1'b0, 1'b0, '0, 32'h0, 3'b0);
        set_req(1'b1, 1'b0, 1'b0, '0, 32'h0, 3'b0);
        mdl_last = 1'b1;
        test_reset();
        test_arbitration();
        test_word();
        test_sign();
        test_misalign();
        test_reset_mid();
        test_cancel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
